// File: rtl/fifo_wr_arb_pkg.sv
// Shared definitions for the two-requester FIFO write arbiter.
package fifo_wr_arb_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  // A burst closes on a byte flagged last or on the byte that reaches the cap.
  function automatic logic burst_done(input logic [3:0] cnt_next,
                                      input logic [3:0] max_cnt,
                                      input logic       last);
    return last || (cnt_next == max_cnt);
  endfunction

endpackage

// File: rtl/fifo_wr_arb_rr_pick2.sv
// Two-way round-robin pick; ptr names the requester served last.
module rr_pick2 (
  input  logic       req0,
  input  logic       req1,
  input  logic       ptr,
  output logic [1:0] pick
);

  // one-hot choice, the requester not served last wins a tie
  always_comb begin
    pick = 2'b00;
    if (req0 && req1) begin
      pick = ptr ? 2'b01 : 2'b10;
    end else if (req0) begin
      pick = 2'b01;
    end else if (req1) begin
      pick = 2'b10;
    end else begin
      pick = 2'b00;
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Grants one of two byte requesters the FIFO write port for a bounded burst.
module fifo_wr_arb
  import fifo_wr_arb_pkg::*;
#(
  parameter int MAXBURST = 8
) (
  input  logic              ck,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [DATA_W-1:0] d0,
  input  logic [DATA_W-1:0] d1,
  input  logic              last0,
  input  logic              last1,
  input  logic              Ffull,
  output logic              gnt0,
  output logic              gnt1,
  output logic              ack0,
  output logic              ack1,
  output logic              Wen,
  output logic [DATA_W-1:0] Din
);

  localparam logic [3:0] MAXB_C = 4'(MAXBURST);

  arb_state_e  state_r, state_nxt_s;
  logic [3:0]  cnt_r, cnt_nxt_s;
  logic        ptr_r, ptr_nxt_s;
  logic [1:0]  pick_s;
  logic        own_req_s, own_last_s, oth_req_s, wen_s, done_s;

  rr_pick2 u_pick (
    .req0 (req0),
    .req1 (req1),
    .ptr  (ptr_r),
    .pick (pick_s)
  );

  assign gnt0 = (state_r == OWN0);
  assign gnt1 = (state_r == OWN1);

  // state, burst count and last-served pointer; pointer resets to 1 so req0 wins the first tie
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      ptr_r   <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      ptr_r   <= ptr_nxt_s;
    end
  end

  // owner's request/last/data and the combinational write strobe
  always_comb begin
    own_req_s  = 1'b0;
    own_last_s = 1'b0;
    oth_req_s  = 1'b0;
    Din        = {DATA_W{1'b0}};
    case (state_r)
      OWN0: begin
        own_req_s  = req0;
        own_last_s = last0;
        oth_req_s  = req1;
        Din        = d0;
      end
      OWN1: begin
        own_req_s  = req1;
        own_last_s = last1;
        oth_req_s  = req0;
        Din        = d1;
      end
      default: begin
        own_req_s  = 1'b0;
        own_last_s = 1'b0;
        oth_req_s  = 1'b0;
        Din        = {DATA_W{1'b0}};
      end
    endcase
    wen_s = own_req_s & ~Ffull;
    Wen   = wen_s;
    ack0  = wen_s & gnt0;
    ack1  = wen_s & gnt1;
  end

  // next grant; a finishing owner hands straight over to a waiting peer
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    ptr_nxt_s   = ptr_r;
    done_s      = 1'b0;
    case (state_r)
      IDLE: begin
        cnt_nxt_s = 4'd0;
        if (pick_s[0]) begin
          state_nxt_s = OWN0;
        end else if (pick_s[1]) begin
          state_nxt_s = OWN1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      OWN0, OWN1: begin
        if (!own_req_s) begin
          done_s = 1'b1;
        end else if (wen_s) begin
          cnt_nxt_s = cnt_r + 4'd1;
          done_s    = burst_done(cnt_r + 4'd1, MAXB_C, own_last_s);
        end else begin
          done_s = 1'b0;
        end
        if (done_s) begin
          ptr_nxt_s = (state_r == OWN1);
          cnt_nxt_s = 4'd0;
          if (oth_req_s) begin
            state_nxt_s = (state_r == OWN0) ? OWN1 : OWN0;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = 4'd0;
      end
    endcase
  end

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 Parameter MAXBURST, default 8, SHALL set the maximum bytes written per grant; legal range 1..15.
REQ-002 ck  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  in  1  SHALL be an asynchronous, active-high reset.
REQ-004 req0, req1  in  1 each  SHALL be requester i holding a byte to write.
REQ-005 d0, d1  in  8 each  SHALL be the requester i data byte.
REQ-006 last0, last1  in  1 each  SHALL mark d_i as the final byte of requester i's burst.
REQ-007 gnt0, gnt1  out  1 each  SHALL be requester i owning the FIFO write port (registered).
REQ-008 ack0, ack1  out  1 each  SHALL mean d_i is written at this clock edge.
REQ-009 Wen  out  1  SHALL be the FIFO write enable.
REQ-010 Din  out  8  SHALL be the FIFO write data.
REQ-011 Ffull  in  1  SHALL be the FIFO full flag.

Function
REQ-012 States SHALL be IDLE, OWN0, OWN1; gnt0=(state==OWN0), gnt1=(state==OWN1), never both high.
REQ-013 IDLE: with exactly one req high, SHALL go to that requester's OWN state next cycle; with both high, SHALL grant the requester not served last (rr pointer).
REQ-014 Grant latency SHALL be one cycle: a req rising in IDLE sees gnt on the next cycle.
REQ-015 Wen SHALL be combinational: gnt_i & req_i & !Ffull; Din SHALL be d_i of the owner, 0 when no owner.
REQ-016 ack_i SHALL equal Wen & gnt_i; Wen=1 means one byte is transferred per cycle.
REQ-017 Ffull=1 SHALL stall: Wen=0, ack=0, burst count and state held.
REQ-018 A 4-bit burst counter SHALL clear on grant entry and increment on each ack.
REQ-019 Grant SHALL end on an ack with last_i=1, on an ack that makes the count equal MAXBURST, or on req_i=0 while owning (abandon, no write).
REQ-020 At grant end, SHALL go directly to the other OWN state if the other req is high, else to IDLE; no idle bubble.
REQ-021 The rr pointer SHALL update to the ending owner at every grant end, including abandon.
REQ-022 A req_i high in the OWN_i state's final ack cycle with the other req low SHALL return to IDLE, then be re-granted one cycle later.
REQ-023 With MAXBURST=1, each ack SHALL end the grant; both requesters high SHALL alternate bytes every cycle.

Reset
REQ-024 rst high SHALL asynchronously force state IDLE, counter 0, rr pointer favouring req0; gnt0=gnt1=0; Wen=ack0=ack1=0; Din=0.
REQ-025 rst asserted mid-burst SHALL drop the grant immediately; no byte is acknowledged while rst is high.
REQ-026 After rst deasserts, arbitration SHALL resume from IDLE on the first clock edge.

Structure
REQ-027 A shared package SHALL hold the state encoding (IDLE=2'd0, OWN0=2'd1, OWN1=2'd2) and the data width constant 8.
REQ-028 The round-robin pick SHALL be a sub-module rr_pick2 (inputs req0, req1, pointer; outputs one-hot pick); all other logic stays in fifo_wr_arb.

Verification
REQ-029 req0=1 only, d0=8'h11..8'h13, last0 on 8'h13, Ffull=0 -> gnt0 one cycle after req0; acks on 3 consecutive cycles; Din=11,12,13; IDLE after 8'h13.
REQ-030 req0=req1=1 from reset, last on every byte, MAXBURST=8 -> owner order 0,1,0,1; one byte per cycle; Wen never low.
REQ-031 req1=1 with last1=0 throughout, MAXBURST=8 -> exactly 8 acks, then grant ends and IDLE or OWN0 per req0.
REQ-032 Owner 0 has 2 bytes acked, then Ffull=1 for 4 cycles -> Wen=ack0=0 for those cycles; count stays 2; writes resume when Ffull falls.
REQ-033 Owner 1, req1 drops mid-burst while req0=1 -> next cycle gnt0=1, no Wen in the drop cycle.
REQ-034 rst pulsed asynchronously between edges during OWN0 -> gnt0, Wen and ack0 fall immediately; first grant after release follows the req0-first priority.
